// File: rtl/bcd_display_scan.sv
// bcd_display_scan: time-multiplexed common-anode seven-segment driver for packed BCD digits.
//
// A refresh prescaler paces a digit-scan sequencer. bcd_in is copied into a shadow register
// once per frame, on the tick that wraps the scan back to digit 0, so counters changing
// mid-frame never tear the display. The output stage is registered with one cycle of latency.
//
// Parameters:
//   N_DIGITS    - number of BCD digits scanned (1..8)
//   REFRESH_DIV - clk cycles each digit stays lit (>= 2)
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous active-low reset
//   bcd_in     - packed BCD digits, digit k = bcd_in[4k+3:4k], digit 0 least significant
//   seg        - active-low segments {g,f,e,d,c,b,a}
//   an         - active-low anode enables, one-hot-cold, an[k] selects digit k
//   frame_done - one-cycle pulse following each snapshot of bcd_in
//
// Optional feature (macro BCD_DISPLAY_LZ_BLANK_EN): leading-zero blanking. A scanned digit
// k > 0 whose shadow digits k..N_DIGITS-1 are all zero is driven dark while its anode still
// turns on, so scan timing is unchanged. Digit 0 is never blanked.

module bcd_display_scan #(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*N_DIGITS-1:0]   bcd_in,
  output logic [6:0]              seg,
  output logic [N_DIGITS-1:0]     an,
  output logic                    frame_done
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam int unsigned IdxW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(N_DIGITS - 1);

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [4*N_DIGITS-1:0] shadow_q, shadow_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  frame_done_q, frame_done_d;

  logic       tick;
  logic       wrap;
  logic [3:0] cur_digit;
  logic       blank;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;  // invalid code shows a dash
    endcase
    return s;
  endfunction

  // Prescaler, scan sequencer and frame snapshot.
  always_comb begin
    tick         = (cnt_q == CntMax);
    wrap         = tick && (idx_q == IdxMax);
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    idx_d        = idx_q;
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end
    shadow_d     = wrap ? bcd_in : shadow_q;
    frame_done_d = wrap;
  end

`ifdef BCD_DISPLAY_LZ_BLANK_EN
  // upper_zero[k]: shadow digits k..N_DIGITS-1 are all zero (invalid codes count as non-zero).
  logic [N_DIGITS-1:0] upper_zero;

  always_comb begin
    upper_zero = '0;
    upper_zero[N_DIGITS-1] = (shadow_q[4*(N_DIGITS-1) +: 4] == 4'd0);
    for (int k = int'(N_DIGITS) - 2; k >= 0; k--) begin
      upper_zero[k] = upper_zero[k+1] && (shadow_q[4*k +: 4] == 4'd0);
    end
  end

  always_comb begin
    blank = 1'b0;
    for (int k = 1; k < int'(N_DIGITS); k++) begin
      if (idx_q == IdxW'(k)) begin
        blank = upper_zero[k];
      end
    end
  end
`else
  assign blank = 1'b0;
`endif

  // Output stage next-state: anode select and decoded segments for the current digit.
  always_comb begin
    cur_digit = 4'd0;
    an_d      = '1;
    for (int k = 0; k < int'(N_DIGITS); k++) begin
      if (idx_q == IdxW'(k)) begin
        cur_digit = shadow_q[4*k +: 4];
        an_d[k]   = 1'b0;
      end
    end
    seg_d = blank ? 7'h7F : decode(cur_digit);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Self-checking bench for bcd_display_scan with N_DIGITS=4, REFRESH_DIV=4.
// Expected output for each cycle is pushed to a scoreboard queue before the clock edge and
// popped and compared just after it.

module tb_bcd_display_scan;

  logic        clk;
  logic        reset;
  logic [15:0] bcd_in;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int checks;
  int failures;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fd;
  } exp_t;

  exp_t sb[$];

  bcd_display_scan #(
    .N_DIGITS   (4),
    .REFRESH_DIV(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bcd_in    (bcd_in),
    .seg       (seg),
    .an        (an),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected segment pattern for digit d of a displayed value.
  function automatic logic [6:0] dec(input logic [15:0] v, input int d);
    logic [3:0] x;
    logic [6:0] s;
    x = v[4*d +: 4];
    case (x)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
`ifdef BCD_DISPLAY_LZ_BLANK_EN
    if (d > 0 && (v >> (4 * d)) == 16'h0000) s = 7'h7F;
`endif
    return s;
  endfunction

  task automatic cycle_check(input string tag, input exp_t e);
    exp_t x;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    checks++;
    assert (an === x.an) else begin
      failures++;
      $error("FAIL %s an observed=%h expected=%h", tag, an, x.an);
    end
    checks++;
    assert (seg === x.seg) else begin
      failures++;
      $error("FAIL %s seg observed=%h expected=%h", tag, seg, x.seg);
    end
    checks++;
    assert (frame_done === x.fd) else begin
      failures++;
      $error("FAIL %s frame_done observed=%b expected=%b", tag, frame_done, x.fd);
    end
  endtask

  // One frame of output: digit d lit for cycles 4d..4d+3, frame_done on the last cycle.
  // Optionally drives a new bcd_in right after the check at cycle chg_at.
  task automatic frame(input string tag, input logic [15:0] shown, input int ncyc,
                       input int chg_at, input logic [15:0] chg_val);
    exp_t       e;
    logic [3:0] one;
    int         d;
    one = 4'b0001;
    for (int c = 0; c < ncyc; c++) begin
      d     = c / 4;
      e.an  = ~(one << d);
      e.seg = dec(shown, d);
      e.fd  = (c == 15);
      cycle_check($sformatf("%s[%0d]", tag, c), e);
      if (c == chg_at) bcd_in = chg_val;
    end
  endtask

  initial begin
    exp_t dark;
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bcd_in   = 16'h1234;
    dark     = '{an: 4'hF, seg: 7'h7F, fd: 1'b0};

    for (int i = 0; i < 3; i++) cycle_check("reset_hold", dark);
    reset = 1'b1;

    frame("f1_zero", 16'h0000, 16, -1, 16'h0000);   // shadow still zero until first wrap
    frame("f2_1234", 16'h1234, 16, -1, 16'h0000);
    frame("f3_tear", 16'h1234, 16, 8, 16'h9876);    // change while digit_idx=2
    frame("f4_9876", 16'h9876, 16, 0, 16'hFA05);
    frame("f5_inv",  16'hFA05, 16, -1, 16'h0000);
    frame("f6_part", 16'hFA05, 12, -1, 16'h0000);   // stop with digit_idx=3

    reset = 1'b0;
    cycle_check("mid_reset", dark);
    bcd_in = 16'h0040;
    reset  = 1'b1;

    frame("f7_zero", 16'h0000, 16, -1, 16'h0000);
    frame("f8_0040", 16'h0040, 16, 0, 16'h0000);
    frame("f9_0000", 16'h0000, 16, -1, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
